// File: rtl/rf_issue_stage.sv
// Operand/issue stage for a 3-bit-op ALU: decodes R-type words, reads a 32-entry
// register file with result forwarding, registers operands toward EX and writes back.
module rf_issue_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic              hold,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              ex_valid,
    output logic              wb_en,
    output logic [4:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              illegal,
    output logic [CNT_W-1:0]  illegal_cnt
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_NOR = 3'b100,
        OP_SLT = 3'b101
    } alu_op_e;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    logic [DATA_W-1:0] rf [0:31];
    logic [4:0]        ex_rd;

    logic [5:0] opcode;
    logic [4:0] rs, rt, rd;
    logic [5:0] funct;
    logic       unused_shamt;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign funct  = instr[5:0];
    // The shift-amount field has no meaning for this ALU and is ignored.
    assign unused_shamt = ^instr[10:6];

    logic accept, retire;
    assign accept = in_valid && !hold;
    assign retire = ex_valid && !hold;

    assign in_ready = ~hold;

    logic    dec_legal;
    alu_op_e dec_op;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = OP_ADD;
        if (opcode == 6'd0) begin
            dec_legal = 1'b1;
            case (funct)
                FN_ADD:  dec_op = OP_ADD;
                FN_SUB:  dec_op = OP_SUB;
                FN_AND:  dec_op = OP_AND;
                FN_OR:   dec_op = OP_OR;
                FN_NOR:  dec_op = OP_NOR;
                FN_SLT:  dec_op = OP_SLT;
                default: dec_legal = 1'b0;
            endcase
        end
    end

    // The result retiring this edge is newer than the register file contents.
    logic [DATA_W-1:0] rs_val, rt_val;

    always_comb begin
        rs_val = rf[rs];
        if (rs == 5'd0)
            rs_val = '0;
        else if (retire && rs == ex_rd)
            rs_val = alu_result;
    end

    always_comb begin
        rt_val = rf[rt];
        if (rt == 5'd0)
            rt_val = '0;
        else if (retire && rt == ex_rd)
            rt_val = alu_result;
    end

    assign wb_en   = retire && (ex_rd != 5'd0);
    assign wb_addr = ex_rd;
    assign wb_data = alu_result;

    assign dbg_data = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];

    // NOTE: the register file is reset like ordinary flops because reset must
    // leave every register architecturally zero; this rules out a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                rf[i] <= '0;
        end else if (wb_en) begin
            rf[ex_rd] <= alu_result;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement or block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= 3'b000;
            ex_rd       <= 5'd0;
            ex_valid    <= 1'b0;
            illegal     <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            illegal <= accept && !dec_legal;
            if (accept && !dec_legal && illegal_cnt != {CNT_W{1'b1}})
                illegal_cnt <= illegal_cnt + 1'b1;

            if (accept && dec_legal) begin
                alu_a    <= rs_val;
                alu_b    <= rt_val;
                alu_op   <= dec_op;
                ex_rd    <= rd;
                ex_valid <= 1'b1;
            end else if (!hold) begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule
